// File: rtl/speed_ctrl_pkg.sv
// rtl/speed_ctrl_pkg.sv - shared state encoding and default ramp constants
package speed_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_ACCEL  = 3'd1,
    ST_CRUISE = 3'd2,
    ST_COAST  = 3'd3,
    ST_BRAKE  = 3'd4
  } ramp_state_t;

  localparam int DEF_SPEED_MAX  = 200;
  localparam int DEF_ACC_STEP   = 2;
  localparam int DEF_BRAKE_STEP = 8;
  localparam int DEF_PRESC      = 4;

endpackage

// File: rtl/req_qualifier.sv
// rtl/req_qualifier.sv - two-cycle request qualifier; q only when req is high now and last cycle
module req_qualifier (
  input  logic clk,
  input  logic clr_bar,
  input  logic req,
  output logic q
);

  logic prev_req;

  always_ff @(posedge clk or negedge clr_bar) begin
    if (!clr_bar) prev_req <= 1'b0;
    else          prev_req <= req;
  end

  assign q = req & prev_req;

endmodule

// File: rtl/speed_ramp_ctrl.sv
// rtl/speed_ramp_ctrl.sv - pedal/brake driven speed ramp FSM with prescaled step updates
module speed_ramp_ctrl
  import speed_ctrl_pkg::*;
#(
  parameter int SPEED_W    = 8,
  parameter int SPEED_MAX  = DEF_SPEED_MAX,
  parameter int ACC_STEP   = DEF_ACC_STEP,
  parameter int BRAKE_STEP = DEF_BRAKE_STEP,
  parameter int PRESC      = DEF_PRESC
) (
  input  logic               clk,
  input  logic               clr_bar,
  input  logic               accel_req,
  input  logic               brake_req,
  input  logic               cruise_en,
  output logic [SPEED_W-1:0] speed,
  output logic [2:0]         state,
  output logic               at_max,
  output logic               at_zero,
  output logic               brake_lamp
);

  localparam int PRESC_W = (PRESC > 1) ? $clog2(PRESC) : 1;
  localparam logic [PRESC_W-1:0] PRESC_LAST = PRESC_W'(PRESC - 1);
  localparam logic [PRESC_W-1:0] PRESC_ONE  = PRESC_W'(1);
  localparam logic [SPEED_W:0]   MAX_X      = (SPEED_W + 1)'(SPEED_MAX);
  localparam logic [SPEED_W:0]   ACC_X      = (SPEED_W + 1)'(ACC_STEP);
  localparam logic [SPEED_W:0]   BRK_X      = (SPEED_W + 1)'(BRAKE_STEP);
  localparam logic [SPEED_W:0]   ONE_X      = (SPEED_W + 1)'(1);

  ramp_state_t          state_q, state_d;
  logic [SPEED_W-1:0]   speed_q, speed_d;
  logic [PRESC_W-1:0]   presc_cnt;
  logic                 step_en, accel_q, brake_q, speed_zero;
  logic [SPEED_W:0]     speed_x, inc_x, coast_x, brake_x;

  req_qualifier u_accel_qual (.clk(clk), .clr_bar(clr_bar), .req(accel_req), .q(accel_q));
  req_qualifier u_brake_qual (.clk(clk), .clr_bar(clr_bar), .req(brake_req), .q(brake_q));

  assign speed_zero = (speed_q == '0);
  assign step_en    = (presc_cnt == PRESC_LAST);

  always_comb begin
    state_d = state_q;
    if (brake_q) begin
      state_d = ST_BRAKE;
    end else begin
      case (state_q)
        ST_IDLE:   if (accel_q) state_d = ST_ACCEL;
        ST_ACCEL: begin
          if (!accel_q) begin
            if (cruise_en) state_d = ST_CRUISE;
            else           state_d = ST_COAST;
          end
        end
        ST_CRUISE: begin
          if (accel_q)         state_d = ST_ACCEL;
          else if (!cruise_en) state_d = ST_COAST;
        end
        ST_COAST: begin
          if (accel_q)         state_d = ST_ACCEL;
          else if (speed_zero) state_d = ST_IDLE;
        end
        ST_BRAKE: begin
          if (accel_q)         state_d = ST_ACCEL;
          else if (speed_zero) state_d = ST_IDLE;
          else if (cruise_en)  state_d = ST_CRUISE;
          else                 state_d = ST_COAST;
        end
        default:               state_d = ST_IDLE;
      endcase
    end
  end

  // One extra bit: carry flags overshoot, borrow flags underflow, so speed never wraps
  always_comb begin
    speed_x = {1'b0, speed_q};
    inc_x   = speed_x + ACC_X;
    coast_x = speed_x - ONE_X;
    brake_x = speed_x - BRK_X;
    speed_d = speed_q;
    if (step_en) begin
      case (state_q)
        ST_ACCEL: speed_d = (inc_x > MAX_X) ? MAX_X[SPEED_W-1:0] : inc_x[SPEED_W-1:0];
        ST_COAST: speed_d = coast_x[SPEED_W] ? '0 : coast_x[SPEED_W-1:0];
        ST_BRAKE: speed_d = brake_x[SPEED_W] ? '0 : brake_x[SPEED_W-1:0];
        default:  speed_d = speed_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge clr_bar) begin
    if (!clr_bar) begin
      state_q   <= ST_IDLE;
      speed_q   <= '0;
      presc_cnt <= '0;
    end else begin
      state_q <= state_d;
      speed_q <= speed_d;
      if ((state_d != state_q) || step_en) presc_cnt <= '0;
      else                                 presc_cnt <= presc_cnt + PRESC_ONE;
    end
  end

  assign speed      = speed_q;
  assign state      = state_q;
  assign at_max     = ({1'b0, speed_q} == MAX_X);
  assign at_zero    = speed_zero;
  assign brake_lamp = (state_q == ST_BRAKE);

endmodule

// File: tb/tb_speed_ramp_ctrl.sv
// tb/tb_speed_ramp_ctrl.sv - directed and randomized checks of speed_ramp_ctrl against a behavioural model
module tb_speed_ramp_ctrl;
  import speed_ctrl_pkg::*;

  localparam int MAXV = 200;
  localparam int ACC  = 2;
  localparam int BRK  = 8;
  localparam int PRE  = 4;

  logic       clk = 1'b0;
  logic       clr_bar, accel_req, brake_req, cruise_en;
  logic [7:0] speed;
  logic [2:0] state;
  logic       at_max, at_zero, brake_lamp;

  int checks = 0;
  int passes = 0;

  ramp_state_t m_state;
  int          m_speed, m_age;
  bit          m_pa, m_pb;

  speed_ramp_ctrl dut (
    .clk(clk), .clr_bar(clr_bar), .accel_req(accel_req), .brake_req(brake_req),
    .cruise_en(cruise_en), .speed(speed), .state(state), .at_max(at_max),
    .at_zero(at_zero), .brake_lamp(brake_lamp)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic model_reset();
    m_state = ST_IDLE;
    m_speed = 0;
    m_age   = 0;
    m_pa    = 1'b0;
    m_pb    = 1'b0;
  endtask

  // Behavioural model: step falls on every PRE-th cycle since state entry
  task automatic model_step();
    bit aq, bq, step;
    ramp_state_t ns;
    int sp;
    aq   = accel_req && m_pa;
    bq   = brake_req && m_pb;
    step = (m_age % PRE) == PRE - 1;
    ns   = m_state;
    if (bq) ns = ST_BRAKE;
    else begin
      case (m_state)
        ST_IDLE:   if (aq) ns = ST_ACCEL;
        ST_ACCEL:  if (!aq) begin if (cruise_en) ns = ST_CRUISE; else ns = ST_COAST; end
        ST_CRUISE: begin if (aq) ns = ST_ACCEL; else if (!cruise_en) ns = ST_COAST; end
        ST_COAST:  begin if (aq) ns = ST_ACCEL; else if (m_speed == 0) ns = ST_IDLE; end
        default: begin
          if (aq) ns = ST_ACCEL;
          else if (m_speed == 0) ns = ST_IDLE;
          else if (cruise_en) ns = ST_CRUISE;
          else ns = ST_COAST;
        end
      endcase
    end
    sp = m_speed;
    if (step) begin
      if (m_state == ST_ACCEL) sp = (sp + ACC > MAXV) ? MAXV : sp + ACC;
      if (m_state == ST_COAST) sp = (sp < 1) ? 0 : sp - 1;
      if (m_state == ST_BRAKE) sp = (sp < BRK) ? 0 : sp - BRK;
    end
    m_age   = (ns != m_state) ? 0 : m_age + 1;
    m_state = ns;
    m_speed = sp;
    m_pa    = accel_req;
    m_pb    = brake_req;
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    @(negedge clk);
  endtask

  task automatic do_reset();
    clr_bar = 1'b0; accel_req = 1'b0; brake_req = 1'b0; cruise_en = 1'b0;
    model_reset();
    @(negedge clk);
    clr_bar = 1'b1;
  endtask

  task automatic ramp_to(input int target);
    int n;
    n = 0;
    do_reset();
    accel_req = 1'b1;
    while (m_speed != target && n < 1000) begin tick(); n++; end
    checks++;
    if (speed !== 8'(target) || state !== ST_ACCEL)
      $display("FAIL ramp_to: speed=%0d state=%0d, want speed=%0d state=%0d", speed, state, target, ST_ACCEL);
    else passes++;
  endtask

  task automatic test_reset();
    clr_bar = 1'b0; accel_req = 1'b0; brake_req = 1'b0; cruise_en = 1'b0;
    #2;
    model_reset();
    checks++;
    if (state !== ST_IDLE || speed !== 8'd0 || at_zero !== 1'b1 || at_max !== 1'b0 || brake_lamp !== 1'b0)
      $display("FAIL reset: state=%0d speed=%0d zero=%b max=%b lamp=%b, want 0 0 1 0 0",
               state, speed, at_zero, at_max, brake_lamp);
    else passes++;
    @(negedge clk);
    clr_bar = 1'b1;
  endtask

  task automatic test_single_pulse();
    do_reset();
    accel_req = 1'b1;
    tick();
    accel_req = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      checks++;
      if (state !== ST_IDLE || speed !== 8'd0)
        $display("FAIL single_pulse cyc %0d: state=%0d speed=%0d, want 0 0", i, state, speed);
      else passes++;
    end
  endtask

  task automatic test_accel_ramp();
    do_reset();
    accel_req = 1'b1;
    tick();
    checks++;
    if (state !== ST_IDLE) $display("FAIL accel_first_cycle: state=%0d, want %0d", state, ST_IDLE);
    else passes++;
    tick();
    checks++;
    if (state !== ST_ACCEL) $display("FAIL accel_entry: state=%0d, want %0d", state, ST_ACCEL);
    else passes++;
    for (int i = 2; i < 120; i++) begin
      tick();
      checks++;
      if (speed !== 8'(m_speed) || state !== m_state)
        $display("FAIL accel_ramp cyc %0d: speed=%0d state=%0d, want %0d %0d", i, speed, state, m_speed, m_state);
      else passes++;
    end
    checks++;
    if (speed !== 8'd58) $display("FAIL accel_120: speed=%0d, want 58", speed);
    else passes++;
    for (int i = 0; i < 400; i++) begin
      tick();
      checks++;
      if (speed > 8'd200 || speed !== 8'(m_speed))
        $display("FAIL accel_sat cyc %0d: speed=%0d, want %0d (<=200)", i, speed, m_speed);
      else passes++;
    end
    checks++;
    if (speed !== 8'd200 || at_max !== 1'b1 || state !== ST_ACCEL)
      $display("FAIL accel_max: speed=%0d at_max=%b state=%0d, want 200 1 %0d", speed, at_max, state, ST_ACCEL);
    else passes++;
  endtask

  task automatic test_cruise_coast();
    ramp_to(100);
    cruise_en = 1'b1;
    accel_req = 1'b0;
    tick();
    checks++;
    if (state !== ST_CRUISE || speed !== 8'd100)
      $display("FAIL cruise_entry: state=%0d speed=%0d, want %0d 100", state, speed, ST_CRUISE);
    else passes++;
    for (int i = 0; i < 60; i++) begin
      tick();
      checks++;
      if (state !== ST_CRUISE || speed !== 8'd100)
        $display("FAIL cruise_hold cyc %0d: state=%0d speed=%0d, want %0d 100", i, state, speed, ST_CRUISE);
      else passes++;
    end
    cruise_en = 1'b0;
    tick();
    checks++;
    if (state !== ST_COAST || speed !== 8'd100)
      $display("FAIL coast_entry: state=%0d speed=%0d, want %0d 100", state, speed, ST_COAST);
    else passes++;
    for (int i = 1; i <= 4; i++) begin
      tick();
      checks++;
      if (speed !== ((i == 4) ? 8'd99 : 8'd100))
        $display("FAIL coast_step cyc %0d: speed=%0d, want %0d", i, speed, (i == 4) ? 99 : 100);
      else passes++;
    end
  endtask

  task automatic test_brake_combo();
    int exp_sp;
    ramp_to(100);
    cruise_en = 1'b1;
    accel_req = 1'b0;
    tick();
    accel_req = 1'b1;
    brake_req = 1'b1;
    tick();
    tick();
    checks++;
    if (state !== ST_BRAKE || brake_lamp !== 1'b1 || speed !== 8'd100)
      $display("FAIL brake_entry: state=%0d lamp=%b speed=%0d, want %0d 1 100", state, brake_lamp, speed, ST_BRAKE);
    else passes++;
    for (int k = 1; k <= 15; k++) begin
      repeat (PRE) tick();
      exp_sp = (100 - BRK * k < 0) ? 0 : 100 - BRK * k;
      checks++;
      if (speed !== 8'(exp_sp) || state !== ST_BRAKE || brake_lamp !== 1'b1)
        $display("FAIL brake_step %0d: speed=%0d state=%0d lamp=%b, want %0d %0d 1", k, speed, state, brake_lamp, exp_sp, ST_BRAKE);
      else passes++;
    end
    accel_req = 1'b0;
    brake_req = 1'b0;
    tick();
    checks++;
    if (state !== ST_IDLE || brake_lamp !== 1'b0 || at_zero !== 1'b1)
      $display("FAIL brake_release: state=%0d lamp=%b zero=%b, want %0d 0 1", state, brake_lamp, at_zero, ST_IDLE);
    else passes++;
  endtask

  task automatic test_coast_low();
    ramp_to(4);
    cruise_en = 1'b0;
    accel_req = 1'b0;
    tick();
    for (int v = 3; v >= 0; v--) begin
      repeat (PRE) tick();
      checks++;
      if (speed !== 8'(v) || state !== ST_COAST)
        $display("FAIL coast_low v=%0d: speed=%0d state=%0d, want %0d %0d", v, speed, state, v, ST_COAST);
      else passes++;
    end
    tick();
    checks++;
    if (state !== ST_IDLE || speed !== 8'd0)
      $display("FAIL coast_to_idle: state=%0d speed=%0d, want %0d 0", state, speed, ST_IDLE);
    else passes++;
  endtask

  task automatic test_reset_mid_ramp();
    ramp_to(50);
    @(posedge clk);
    #2;
    clr_bar = 1'b0;
    #1;
    checks++;
    if (state !== ST_IDLE || speed !== 8'd0 || at_zero !== 1'b1)
      $display("FAIL reset_async: state=%0d speed=%0d zero=%b, want %0d 0 1", state, speed, at_zero, ST_IDLE);
    else passes++;
    @(negedge clk);
    clr_bar = 1'b1;
    model_reset();
    tick();
    checks++;
    if (state !== ST_IDLE || speed !== 8'd0)
      $display("FAIL reset_requal_1: state=%0d speed=%0d, want %0d 0", state, speed, ST_IDLE);
    else passes++;
    tick();
    checks++;
    if (state !== ST_ACCEL || speed !== 8'd0)
      $display("FAIL reset_requal_2: state=%0d speed=%0d, want %0d 0", state, speed, ST_ACCEL);
    else passes++;
  endtask

  task automatic test_random();
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 7) == 0) accel_req = ~accel_req;
      if ($urandom_range(0, 19) == 0) brake_req = ~brake_req;
      if ($urandom_range(0, 29) == 0) cruise_en = ~cruise_en;
      tick();
      checks++;
      if (speed !== 8'(m_speed) || state !== m_state || at_max !== (m_speed == MAXV) ||
          at_zero !== (m_speed == 0) || brake_lamp !== (m_state == ST_BRAKE))
        $display("FAIL random cyc %0d: speed=%0d state=%0d max=%b zero=%b lamp=%b, want %0d %0d",
                 i, speed, state, at_max, at_zero, brake_lamp, m_speed, m_state);
      else passes++;
    end
  endtask

  initial begin
    test_reset();
    test_single_pulse();
    test_accel_ramp();
    test_cruise_coast();
    test_brake_combo();
    test_coast_low();
    test_reset_mid_ramp();
    test_random();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
